// File: rtl/risc_v_mike_dmem_lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
//   t_mem_size   : RV32 access size encoding carried on req_size
//   t_dmem_state : sweep/serve state of the data memory
//   BYTES_PER_WORD, lane_misaligned() helper used by the align logic
package risc_v_mike_dmem_lsu_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } t_mem_size;

  typedef enum logic {
    DMEM_INIT = 1'b0,
    DMEM_IDLE = 1'b1
  } t_dmem_state;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Size 3 is not a misalignment; the top reports it separately.
  function automatic logic lane_misaligned(input logic [1:0] off, input logic [1:0] size);
    logic bad;
    bad = 1'b0;
    if (size == MEM_HALF) bad = off[0];
    if (size == MEM_WORD) bad = |off;
    return bad;
  endfunction

endpackage

// File: rtl/risc_v_mike_dmem_lsu_align.sv
// Purely combinational lane logic for the data memory.
//   req_off_i/req_size_i/req_wdata_i : incoming request byte offset, size, store data
//   st_be_o/st_wdata_o               : byte enables and lane-replicated store data
//   misalign_o                       : access not naturally aligned for its size
//   ld_off_i/ld_size_i/ld_unsigned_i : captured load offset, size, zero-extend flag
//   ld_word_i/ld_rdata_o             : raw memory word in, extended load data out
module risc_v_mike_dmem_lsu_align
  import risc_v_mike_dmem_lsu_pkg::*;
(
  input  logic [1:0]  req_off_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  output logic        misalign_o,
  input  logic [1:0]  ld_off_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_rdata_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign misalign_o = lane_misaligned(req_off_i, req_size_i);

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    st_be_o    = '0;
    st_wdata_o = '0;
    case (req_size_i)
      MEM_BYTE: begin
        st_be_o    = 4'b0001 << req_off_i;
        st_wdata_o = {4{req_wdata_i[7:0]}};
      end
      MEM_HALF: begin
        st_be_o    = req_off_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{req_wdata_i[15:0]}};
      end
      MEM_WORD: begin
        st_be_o    = 4'b1111;
        st_wdata_o = req_wdata_i;
      end
      default: begin
        st_be_o    = '0;
        st_wdata_o = '0;
      end
    endcase
  end

  always_comb begin
    ld_byte    = ld_word_i[{ld_off_i, 3'b000} +: 8];
    ld_half    = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    ld_rdata_o = '0;
    case (ld_size_i)
      MEM_BYTE: ld_rdata_o = {{24{~ld_unsigned_i & ld_byte[7]}}, ld_byte};
      MEM_HALF: ld_rdata_o = {{16{~ld_unsigned_i & ld_half[15]}}, ld_half};
      MEM_WORD: ld_rdata_o = ld_word_i;
      default:  ld_rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/risc_v_mike_dmem_lsu.sv
// Byte-addressed RV32 data memory with valid/ready request channel and a
// registered one-cycle response. Array is non-reset (RAM-inferable) and is
// optionally zeroed by a post-reset sweep.
//   clk, rst (async active-low)
//   req_valid/req_ready/req_write/req_addr/req_size/req_unsigned/req_wdata : request
//   rsp_valid/rsp_rdata/rsp_err : response, one cycle after accept
//   init_done : sweep finished, requests accepted
module risc_v_mike_dmem_lsu
  import risc_v_mike_dmem_lsu_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_W     = 32,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  ADDR_LIMIT = (ADDR_W + 1)'(DEPTH * BYTES_PER_WORD);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("risc_v_mike_dmem_lsu: DATA_W must be 32");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("risc_v_mike_dmem_lsu: DEPTH must be a power of two >= 4");
  end

  t_dmem_state      state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             req_ready_q;
  logic             init_done_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic             rsp_ld_q;
  logic [1:0]       rsp_off_q;
  logic [1:0]       rsp_size_q;
  logic             rsp_uns_q;
  logic [31:0]      rd_word_q;
  logic [31:0]      mem_q [DEPTH];

  logic             accept;
  logic             misalign;
  logic             size_illegal;
  logic             out_of_range;
  logic             rsp_err_d;
  logic             st_fire;
  logic             ld_fire;
  logic [IDX_W-1:0] idx;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_rdata;

  assign accept       = req_valid & req_ready_q;
  assign size_illegal = (req_size == 2'd3);
  assign out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);
  assign rsp_err_d    = accept & (misalign | size_illegal | out_of_range);
  assign st_fire      = accept & req_write & ~rsp_err_d;
  assign ld_fire      = accept & ~req_write & ~rsp_err_d;
  assign idx          = req_addr[IDX_W+1:2];

  risc_v_mike_dmem_lsu_align u_align (
    .req_off_i     (req_addr[1:0]),
    .req_size_i    (req_size),
    .req_wdata_i   (req_wdata),
    .st_be_o       (st_be),
    .st_wdata_o    (st_wdata),
    .misalign_o    (misalign),
    .ld_off_i      (rsp_off_q),
    .ld_size_i     (rsp_size_q),
    .ld_unsigned_i (rsp_uns_q),
    .ld_word_i     (rd_word_q),
    .ld_rdata_o    (ld_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= DMEM_INIT;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_ld_q    <= 1'b0;
      rsp_off_q   <= '0;
      rsp_size_q  <= '0;
      rsp_uns_q   <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      rsp_err_q   <= rsp_err_d;
      rsp_ld_q    <= ld_fire;
      if (ld_fire) begin
        rsp_off_q  <= req_addr[1:0];
        rsp_size_q <= req_size;
        rsp_uns_q  <= req_unsigned;
      end
      case (state_q)
        DMEM_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (!INIT_CLEAR || cnt_q == LAST_IDX) begin
            state_q     <= DMEM_IDLE;
            req_ready_q <= 1'b1;
            init_done_q <= 1'b1;
          end
        end
        DMEM_IDLE: begin
          req_ready_q <= 1'b1;
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= DMEM_INIT;
          req_ready_q <= 1'b0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset so it maps onto block RAM; the sweep does the clearing.
  always_ff @(posedge clk) begin
    if (state_q == DMEM_INIT) begin
      if (INIT_CLEAR) mem_q[cnt_q] <= '0;
    end else if (st_fire) begin
      for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
        if (st_be[b]) mem_q[idx][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
    if (ld_fire) rd_word_q <= mem_q[idx];
  end

  assign req_ready = req_ready_q;
  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_ld_q ? ld_rdata : '0;

endmodule
